debug_pattern_gen: RTL
======================

# debug_pattern_gen

Programmable stimulus sequencer that drives an 8-bit debug/trigger bus with a stored sequence of patterns, each held for a programmed number of cycles. It is the driving counterpart of the on-chip logic-analyzer capture path. Its `trg` output feeds the analyzer trigger inputs or the logic under test, so a bench or a ChipScope session can replay known, repeatable sequences. Pattern memory is loaded through a simple write port; playback is started, stopped and looped by single-cycle control pulses.

## Interface
- `WIDTH`, 8: width of each output pattern.
- `DEPTH`, 16: number of pattern entries.
- `AW`, 4: address width, with DEPTH = 2^AW.

- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write strobe for pattern memory.
- `wr_addr`  in  AW  entry index to write.
- `wr_data`  in  WIDTH+8  entry contents: [WIDTH+7:8] = pattern, [7:0] = dwell.
- `last_idx`  in  AW  index of the final entry in the sequence; sampled on start.
- `loops`  in  8  number of sequence passes; 0 = run until stopped; sampled on start.
- `start`  in  1  one-cycle pulse that begins playback.
- `stop`  in  1  one-cycle pulse that aborts playback.
- `trg`  out  WIDTH  registered pattern output.
- `busy`  out  1  high while playback runs.
- `done`  out  1  one-cycle pulse on normal completion.
- `idx`  out  AW  index of the entry currently presented.

## Operation
- Memory: DEPTH x (WIDTH+8) distributed RAM.
  - Synchronous write when `wr_en` = 1; combinational read at the fetch index.
  - Writes are allowed at any time.
  - A write to an entry takes effect at that entry's next fetch. An entry already being presented is not altered mid-dwell.
  - Memory contents are not reset.
- FSM with two states, IDLE and RUN.
- IDLE:
  - `trg` = 0, `busy` = 0, `idx` = 0.
  - `start` = 1 and `stop` = 0 → RUN. Latch `last_idx` and `loops`.
  - Load `trg` = mem[0].pattern and dwell counter = mem[0].dwell.
  - Clear the pass counter to 0.
- RUN:
  - `busy` = 1. Each entry is presented for dwell+1 cycles; dwell = 0 means 1 cycle.
  - Dwell counter > 0: decrement it.
  - Dwell counter = 0 and `idx` != latched last: `idx`+1, fetch that entry.
  - Dwell counter = 0 and `idx` = last:
    - Increment the pass counter (8-bit, wraps).
    - If latched loops = 0, or pass+1 < loops: wrap `idx` to 0 and fetch entry 0.
    - Otherwise: go to IDLE, `trg` = 0, `done` = 1 for one cycle.
- `stop` in RUN: on the next edge go to IDLE, `trg` = 0, `idx` = 0, no `done`. `stop` has priority over every other RUN transition.
- `start` in RUN: ignored; no restart.
- `start` and `stop` together in IDLE: stop wins; remain IDLE.
- `last_idx` of 0: a single-entry sequence.
- Changing `last_idx` or `loops` during RUN has no effect until the next start.
- Reset (asynchronous, any state): IDLE; `trg` = 0, `busy` = 0, `done` = 0, `idx` = 0; counters cleared.
  - Reset mid-run aborts immediately with no `done`.

## Timing
- Start latency: `start` sampled high on edge E → after E, `trg` = mem[0].pattern and `busy` = 1.
- Entry i is visible for exactly dwell_i + 1 cycles. Consecutive entries are back-to-back with no gap cycle, including across the loop wrap.
- Total run length = loops × Σ(dwell_i + 1), over i = 0..last_idx.
- On the edge that ends the final entry, these change together: `trg` → 0, `busy` → 0, `done` → 1 (for one cycle).
- A new `start` is accepted in the cycle `done` is high; playback restarts on the following edge.
- `stop` sampled at edge S → after S, `trg` = 0 and `busy` = 0.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset values: assert `rst_n` = 0 mid-run → `trg` = 0x00, `busy` = 0, `done` = 0, `idx` = 0 asynchronously, with no clock edge needed.
- Basic sequence:
  - Setup: mem[0] = {0xA5, 2}, mem[1] = {0x3C, 0}, mem[2] = {0xFF, 1}; `last_idx` = 2, `loops` = 1; pulse `start`.
  - Expected: `trg` = A5 for 3 cycles, then 3C for 1, then FF for 2. Then `trg` = 00 and `busy` = 0 with `done` pulsing high one cycle; 6 busy cycles total.
- Looping: same memory, `loops` = 3 → 18 busy cycles. A5 follows FF directly at each wrap with no gap; a single `done` at the end.
- Infinite and stop: `loops` = 0 → sequence repeats for more than 100 cycles. Pulse `stop` during entry 1 → `trg` = 00 and `busy` = 0 the next cycle; `done` never asserts.
- Control corner cases:
  - `start` during RUN → no restart and `idx` continues.
  - `start` and `stop` in the same IDLE cycle → stays IDLE.
  - `start` in the `done` cycle → restart with `trg` = A5.
- Live write: during RUN, write mem[2] = {0x11, 0} while entry 1 is shown → 0x11 appears at the next fetch of entry 2.
- Single entry: `last_idx` = 0 with mem[0] = {0x80, 0} and `loops` = 2 → `trg` = 80 for 2 cycles, then `done`.

Source files
------------

// File: rtl/debug_pattern_gen.sv
// Replays a stored sequence of patterns on a debug/trigger bus, holding each for dwell+1 cycles.
// Start, stop and loop are controlled by single-cycle pulses; all outputs are registered.
module debug_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH+7:0] i_wr_data,
    input  logic [AW-1:0]    i_last_idx,
    input  logic [7:0]       i_loops,
    input  logic             i_start,
    input  logic             i_stop,
    output logic [WIDTH-1:0] o_trg,
    output logic             o_busy,
    output logic             o_done,
    output logic [AW-1:0]    o_idx
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic [WIDTH+7:0] r_mem [DEPTH];

    logic             r_state;
    logic [WIDTH-1:0] r_trg;
    logic             r_busy;
    logic             r_done;
    logic [AW-1:0]    r_idx;
    logic [AW-1:0]    r_last;
    logic [7:0]       r_dwell;
    logic [7:0]       r_pass;
    logic [7:0]       r_loops;

    logic             w_at_last;
    logic [AW-1:0]    w_fetch_idx;
    logic [WIDTH+7:0] w_entry;
    logic [7:0]       w_pass_nxt;
    logic             w_more;

    assign w_at_last   = (r_idx == r_last);
    assign w_fetch_idx = ((r_state == ST_IDLE) || w_at_last) ? '0 : r_idx + 1'b1;
    // A write landing on the same edge as the fetch of that entry is forwarded,
    // so the new contents show on this fetch rather than one pass later.
    assign w_entry     = (i_wr_en && (i_wr_addr == w_fetch_idx)) ? i_wr_data : r_mem[w_fetch_idx];
    assign w_pass_nxt  = r_pass + 8'd1;
    assign w_more      = (r_loops == 8'd0) || (w_pass_nxt < r_loops);

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_trg   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_idx   <= '0;
            r_last  <= '0;
            r_dwell <= '0;
            r_pass  <= '0;
            r_loops <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start && !i_stop) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_last  <= i_last_idx;
                        r_loops <= i_loops;
                        r_pass  <= '0;
                        r_idx   <= '0;
                        r_trg   <= w_entry[WIDTH+7:8];
                        r_dwell <= w_entry[7:0];
                    end
                end
                ST_RUN: begin
                    if (i_stop) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_trg   <= '0;
                        r_idx   <= '0;
                        r_dwell <= '0;
                    end else if (r_dwell != 8'd0) begin
                        r_dwell <= r_dwell - 8'd1;
                    end else if (!w_at_last) begin
                        r_idx   <= w_fetch_idx;
                        r_trg   <= w_entry[WIDTH+7:8];
                        r_dwell <= w_entry[7:0];
                    end else begin
                        r_pass <= w_pass_nxt;
                        if (w_more) begin
                            r_idx   <= '0;
                            r_trg   <= w_entry[WIDTH+7:8];
                            r_dwell <= w_entry[7:0];
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_trg   <= '0;
                            r_idx   <= '0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_trg  = r_trg;
    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_idx  = r_idx;

endmodule
